// File: rtl/div_32.sv
// -----------------------------------------------------------------------------
// div_32 : multi-cycle 32-bit restoring divider for the ALU divide slot.
//
// Takes dividend A and divisor B on an accepted start and returns
// {remainder, quotient} in C after 32 restoring steps plus one fix-up cycle.
// The layout of C matches the HI/LO split of the multiply path.
//
// Ports
//   clock        in   1   sole clock, rising edge
//   clear        in   1   asynchronous active-high reset
//   start        in   1   request, only honoured in IDLE
//   A            in  32   dividend, latched on accepted start
//   B            in  32   divisor, latched on accepted start
//   C            out 64   result: C[63:32] remainder, C[31:0] quotient
//   busy         out  1   high while RUN or FIX
//   done         out  1   single-cycle pulse, C valid from this cycle on
//   div_by_zero  out  1   valid with done, set when the latched B was zero
//
// Build option
//   DIV_SIGNED_EN  defined   : two's-complement operands; quotient truncates
//                              toward zero, remainder follows the dividend sign
//                  undefined : unsigned-only division (default)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, operands latched on accepted start
// RUN   | one restoring step per cycle, 32 cycles (counter 31..0)
// FIX   | sign / divide-by-zero correction, register result into C
// DONE  | done pulse for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module div_32 (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] C,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  count;
    logic [31:0] a_raw;
    logic [31:0] dvsr;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        b_zero;

    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    logic [31:0] q_fix;
    logic [31:0] r_fix;

`ifdef DIV_SIGNED_EN
    logic        a_neg;
    logic        q_neg;
`endif

    // ------------------------------------------------------------------
    // Operand magnitudes at latch time
    // ------------------------------------------------------------------
    always_comb begin
`ifdef DIV_SIGNED_EN
        // 0x80000000 negates to itself, which reads correctly as the
        // unsigned magnitude 2^31.
        a_mag = A[31] ? (32'd0 - A) : A;
        b_mag = B[31] ? (32'd0 - B) : B;
`else
        a_mag = A;
        b_mag = B;
`endif
    end

    // ------------------------------------------------------------------
    // One restoring step. The partial remainder is always below the
    // divisor, so after the shift it fits in 33 bits and a 33-bit
    // subtract is enough: bit 32 of the difference is the borrow.
    // ------------------------------------------------------------------
    always_comb begin
        shifted = {rem, quo[31]};
        trial   = shifted - {1'b0, dvsr};
        if (trial[32]) begin
            rem_nxt = shifted[31:0];
        end else begin
            rem_nxt = trial[31:0];
        end
        quo_nxt = {quo[30:0], ~trial[32]};
    end

    // ------------------------------------------------------------------
    // Fix-up of the raw unsigned result
    // ------------------------------------------------------------------
    always_comb begin
`ifdef DIV_SIGNED_EN
        q_fix = q_neg ? (32'd0 - quo) : quo;
        r_fix = a_neg ? (32'd0 - rem) : rem;
`else
        q_fix = quo;
        r_fix = rem;
`endif
        if (b_zero) begin
            q_fix = 32'hFFFF_FFFF;
            r_fix = a_raw;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (count == 5'd0) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count       <= 5'd0;
            a_raw       <= 32'd0;
            dvsr        <= 32'd0;
            rem         <= 32'd0;
            quo         <= 32'd0;
            b_zero      <= 1'b0;
            C           <= 64'd0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            a_neg       <= 1'b0;
            q_neg       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_raw  <= A;
                        dvsr   <= b_mag;
                        rem    <= 32'd0;
                        quo    <= a_mag;
                        count  <= 5'd31;
                        b_zero <= (B == 32'd0);
`ifdef DIV_SIGNED_EN
                        a_neg  <= A[31];
                        q_neg  <= A[31] ^ B[31];
`endif
                    end
                end
                S_RUN: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (count != 5'd0) begin
                        count <= count - 5'd1;
                    end
                end
                S_FIX: begin
                    C           <= {r_fix, q_fix};
                    div_by_zero <= b_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
